// File: rtl/usart_rx_fifo.sv
// Receive-side byte FIFO for a USART: show-ahead read port, occupancy count, sticky overrun.
// Optional macro USART_RX_FIFO_ERR_DROP_EN drops framing-error bytes and counts them in err_count.
module usart_rx_fifo #(
  parameter int MAX_DATA_BUFFER_INDEX = 15
) (
  input  logic                                    clk,
  input  logic                                    reset,
  input  logic                                    rx_valid,
  input  logic [7:0]                              rx_data,
  input  logic                                    rx_frame_err,
  input  logic                                    rd_en,
  output logic [7:0]                              rd_data,
  output logic                                    rd_valid,
  output logic [$clog2(MAX_DATA_BUFFER_INDEX+1):0] count,
  output logic                                    full,
  output logic                                    overrun,
  input  logic                                    clear_overrun
`ifdef USART_RX_FIFO_ERR_DROP_EN
  ,
  output logic [7:0]                              err_count
`endif
);

  localparam int DEPTH = MAX_DATA_BUFFER_INDEX + 1;
  localparam int AW    = $clog2(DEPTH);
  localparam int CW    = AW + 1;

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          overrun_q, overrun_d;
  logic          byte_ok;
  logic          pop;
  logic          wr_en;
  logic          ovf;

`ifdef USART_RX_FIFO_ERR_DROP_EN
  logic [7:0] err_count_q, err_count_d;
  assign byte_ok = ~rx_frame_err;
`else
  logic frame_err_unused;
  assign frame_err_unused = rx_frame_err;
  assign byte_ok = 1'b1;
`endif

  // Status comes from the count register only, never from this cycle's inputs.
  assign rd_valid = (count_q != '0);
  assign full     = (count_q == CW'(DEPTH));
  assign count    = count_q;
  assign overrun  = overrun_q;
  assign rd_data  = rd_valid ? mem_q[rd_ptr_q] : 8'h00;

  always_comb begin
    pop       = rd_en & rd_valid;
    // A pop frees a slot in the same cycle, so a full FIFO can still accept.
    wr_en     = rx_valid & byte_ok & (~full | pop);
    ovf       = rx_valid & byte_ok & full & ~pop;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    overrun_d = overrun_q;
    if (wr_en) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)   rd_ptr_d = rd_ptr_q + AW'(1);
    case ({wr_en, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    // Set beats clear when both happen in one cycle.
    if (ovf)                overrun_d = 1'b1;
    else if (clear_overrun) overrun_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      overrun_q <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      overrun_q <= overrun_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && wr_en) mem_q[wr_ptr_q] <= rx_data;
  end

`ifdef USART_RX_FIFO_ERR_DROP_EN
  always_comb begin
    err_count_d = err_count_q;
    if (rx_valid && rx_frame_err && (err_count_q != 8'hFF)) err_count_d = err_count_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) err_count_q <= 8'd0;
    else       err_count_q <= err_count_d;
  end

  assign err_count = err_count_q;
`endif

endmodule

// File: doc/usart_rx_fifo.md
USART_RX_FIFO -- requirements
Module: usart_rx_fifo

Interface
REQ-001 SHALL have parameter MAX_DATA_BUFFER_INDEX, default 15, meaning highest storage index. Depth is MAX_DATA_BUFFER_INDEX+1 and SHALL be a power of two.
REQ-002 SHALL have port clk, input, 1, the single clock. All logic is clocked on its rising edge.
REQ-003 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-004 SHALL have port rx_valid, input, 1, one-cycle strobe from the receiver marking a completed byte.
REQ-005 SHALL have port rx_data, input, 8, received byte. Sampled only when rx_valid=1.
REQ-006 SHALL have port rx_frame_err, input, 1, stop-bit error flag for the byte qualified by rx_valid.
REQ-007 SHALL have port rd_en, input, 1, consumer pop request.
REQ-008 SHALL have port rd_data, output, 8, head byte (show-ahead).
REQ-009 SHALL have port rd_valid, output, 1, FIFO non-empty.
REQ-010 SHALL have port count, output, clog2(depth)+1, number of stored bytes.
REQ-011 SHALL have port full, output, 1, count equals depth.
REQ-012 SHALL have port overrun, output, 1, sticky flag for a byte lost to full.
REQ-013 SHALL have port clear_overrun, input, 1, clears overrun.

Function
REQ-014 Write: rx_valid=1 and (full=0 or pop this cycle) SHALL store rx_data at the write pointer and advance the write pointer modulo depth.
REQ-015 Pop: rd_en=1 and rd_valid=1 SHALL advance the read pointer modulo depth. rd_en with rd_valid=0 SHALL be ignored.
REQ-016 Latency: a byte written at edge N SHALL appear on rd_data with rd_valid=1 after edge N, when the FIFO was empty. There is no extra read latency.
REQ-017 rd_data SHALL equal the stored head byte when rd_valid=1, and 8'h00 when rd_valid=0.
REQ-018 Bytes SHALL be delivered in arrival order. Pointer wrap SHALL NOT lose or reorder data.
REQ-019 count SHALL increment on write-only, decrement on pop-only, and stay unchanged on simultaneous write and pop.
REQ-020 Full with simultaneous pop and write: both SHALL occur, count stays at depth, overrun stays unchanged.
REQ-021 Empty with simultaneous rd_en and rx_valid: the write SHALL occur, the pop SHALL NOT, and count becomes 1.
REQ-022 rx_valid=1, full=1, no pop: the byte SHALL be discarded, storage SHALL be unchanged, and overrun SHALL be set on the next edge.
REQ-023 clear_overrun=1 SHALL clear overrun on the next edge. If a set and a clear occur in the same cycle, the set SHALL win.
REQ-024 full and rd_valid SHALL be derived from the count register, not computed combinationally from inputs.

Reset
REQ-025 reset=1 at an edge SHALL set both pointers to 0, count to 0, and overrun to 0. This gives rd_valid=0, full=0 and rd_data=8'h00.
REQ-026 Reset SHALL take priority over a simultaneous write, pop or clear. Storage contents need not be cleared.
REQ-027 Reset asserted mid-stream SHALL discard all stored bytes. The first write after reset deasserts SHALL be delivered first.

Configuration
REQ-028 Macro USART_RX_FIFO_ERR_DROP_EN SHALL control frame-error handling.
REQ-029 With USART_RX_FIFO_ERR_DROP_EN defined, a byte with rx_frame_err=1 SHALL NOT be stored and SHALL NOT affect count or overrun. An extra output err_count (8 bits, reset 0, saturating at 255) SHALL increment per dropped byte.
REQ-030 Without USART_RX_FIFO_ERR_DROP_EN, rx_frame_err SHALL be ignored, every byte SHALL follow REQ-014/REQ-022, and err_count SHALL NOT exist.

Verification
REQ-031 Write 8'h41, 8'h42, 8'h43 with no reads -> count=3, rd_data=8'h41; pop thrice -> 8'h42, 8'h43, then rd_valid=0 and rd_data=8'h00.
REQ-032 Write 16 bytes 8'h00..8'h0F -> full=1; write 8'hAA -> overrun=1 and count=16; pop all -> 8'h00..8'h0F in order, with no 8'hAA.
REQ-033 When full, write 8'h55 and pop in the same cycle -> count=16, overrun=0; after 15 more pops rd_data=8'h55.
REQ-034 Fill 10 bytes, pop 10, write 10 more across the wrap -> order preserved and count=10.
REQ-035 Set overrun, then assert clear_overrun coincident with another overflow -> overrun stays 1; clear alone -> overrun=0; reset with count=5 -> count=0, rd_valid=0.
REQ-036 With USART_RX_FIFO_ERR_DROP_EN defined, write 8'h33 with rx_frame_err=1 -> count unchanged, err_count=1; without the macro -> 8'h33 is stored.
